comp_window_ctrl: RTL and testbench
===================================

# comp_window_ctrl

Evaluation-window scheduler for the `comp_edge_resolve` race-logic resolver in the LFSR comparator path.
- Frames each comparison into a fixed-length window: drives the resolver's reset for a clear phase, gates the x/y edges during an arm phase, then captures the resolver's 3-bit mux select.
- Delivers the result downstream over a valid/ready handshake.
- Does not start a new window until the previous result is consumed.

## Interface
Parameters:
- `WIN_LEN`, 16, total window cycles (clear + arm); must be ≥ `CLR_CYC`+2.
- `CLR_CYC`, 2, cycles the resolver is held in reset at window start; must be ≥ 1.
- `SEL_W`, 3, width of resolver select.
- `T_W`, $clog2(`WIN_LEN`), width of first-edge timestamp.

Ports:
- Clocking and reset: one clock; reset is synchronous and active-low.
  - `clk` in 1: clock.
  - `rst_b` in 1: reset.
- `en` in 1: run windows back-to-back while high.
- `x_edge` in 1: raw x edge pulse.
- `y_edge` in 1: raw y edge pulse.
- `x_edge_g` out 1: `x_edge` AND `edge_en`, to resolver.
- `y_edge_g` out 1: `y_edge` AND `edge_en`, to resolver.
- `edge_en` out 1: high only in ARM.
- `res_rst_b` out 1: resolver reset, active-low.
- `res_sel` in `SEL_W`: resolver `to_sel_mux`.
- `sel_out` out `SEL_W`: captured select.
- `no_edge` out 1: no gated edge seen during ARM.
- `first_t` out `T_W`: ARM cycle index of first gated edge.
- `sel_valid` out 1: result valid.
- `sel_ready` in 1: downstream accept.
- `win_cnt` out 16: completed (handshaken) windows.
- `busy` out 1: state ≠ IDLE.

## Operation
- ARM_LEN = `WIN_LEN` − `CLR_CYC`.
- FSM transitions:
  - IDLE → CLEAR when `en`=1.
  - CLEAR (`res_rst_b`=0, `clr_cnt` 0..`CLR_CYC`−1) → ARM after the last clear cycle.
  - ARM (`res_rst_b`=1, `edge_en`=1, `arm_cnt` 0..ARM_LEN−1) → CAPTURE after `arm_cnt`=ARM_LEN−1.
  - CAPTURE (1 cycle, `edge_en`=0, `res_rst_b`=1): registers `res_sel` → `sel_out`, then goes to HOLD.
  - HOLD: `sel_valid`=1; on `sel_valid`&`sel_ready`, `win_cnt`++ (wraps 16'hFFFF→0). Then → CLEAR if `en`=1, else IDLE.
- `res_rst_b`=0 in IDLE and CLEAR.
- First-edge tracking:
  - `seen` flag is cleared in CLEAR.
  - On the first ARM cycle where `x_edge`|`y_edge` is high, `seen` is set and `arm_cnt` is latched into `first_t`.
  - Simultaneous x and y edges are treated as a single first edge.
- `no_edge` = !`seen` at CAPTURE. When `no_edge`=1, `sel_out` is forced to 0 regardless of `res_sel`.
- `en` deasserted mid-window: the current window completes and the handshake is honoured; then IDLE.
- `sel_out`, `no_edge` and `first_t` are stable throughout HOLD.

## Timing
- Reset values, applied on the edge where `rst_b`=0 is sampled:
  - state IDLE.
  - `res_rst_b`=0, `edge_en`=0.
  - `sel_valid`=0, `sel_out`=0, `no_edge`=0, `first_t`=0.
  - `win_cnt`=0, `busy`=0.
- Reset mid-window abandons the window: no valid is produced and `win_cnt` is unchanged.
- Latency, with `en` sampled high at edge k in IDLE:
  - CLEAR at k+1..k+`CLR_CYC`.
  - ARM at k+`CLR_CYC`+1..k+`WIN_LEN`.
  - CAPTURE at k+`WIN_LEN`+1.
  - `sel_valid` rises at k+`WIN_LEN`+2.
  - Default parameters: CLEAR k+1..k+2, ARM k+3..k+16, valid at k+18.
- Back-to-back windows: if `sel_ready`=1 on the first HOLD cycle, the next CLEAR starts the following cycle. Window period is `WIN_LEN`+2 cycles.
- `sel_valid` holds until the handshake and drops the cycle after it.
- All outputs are registered, except `x_edge_g` and `y_edge_g`, which are combinational ANDs.

## Configuration
- `COMP_WIN_TIMESTAMP_EN` defined: first-edge timestamp logic is built and `first_t` behaves as above.
- Not defined: timestamp logic is removed and `first_t` is tied to 0. `seen`/`no_edge` logic remains.

## Test plan
- Reset then `en`=1, `x_edge` high from ARM cycle 3, `y_edge`=0, `res_sel`=3'b001:
  - `res_rst_b`=0 for exactly 2 cycles.
  - `sel_valid` at k+18 with `sel_out`=3'b001, `first_t`=3, `no_edge`=0.
- No edges for the whole ARM phase, `res_sel`=3'b101:
  - `sel_out`=0 and `no_edge`=1.
- `x_edge` and `y_edge` both rise at ARM cycle 0:
  - `first_t`=0.
- `sel_ready`=0 for 5 HOLD cycles, then 1:
  - outputs stable throughout.
  - `win_cnt` increments once.
  - next CLEAR starts the following cycle.
  - edges during HOLD do not reach `x_edge_g`/`y_edge_g`.
- `rst_b`=0 during ARM cycle 7:
  - next cycle shows IDLE reset values.
  - no `sel_valid`, `win_cnt` unchanged.
- Preload `win_cnt`=16'hFFFF via 65535 windows (or force), one more handshake:
  - `win_cnt`=0.
  - `en` dropped mid-ARM still yields one result, then IDLE with `busy`=0.

Source files
------------

// File: rtl/comp_window_ctrl.sv
// -----------------------------------------------------------------------------
// comp_window_ctrl
//
// Evaluation-window scheduler for the comp_edge_resolve race-logic resolver.
// Each window holds the resolver in reset (CLEAR), opens the x/y edge gates
// (ARM), samples the resolver select (CAPTURE) and then presents the result
// on a valid/ready handshake (HOLD). A new window only starts once the
// previous result has been accepted.
//
// Build option:
//   COMP_WIN_TIMESTAMP_EN  defined   -> first-edge timestamp logic is built
//                          undefined -> first_t is tied to 0
//
// Ports:
//   clk        clock
//   rst_b      synchronous active-low reset
//   en         run windows back-to-back while high
//   x_edge     raw x edge pulse
//   y_edge     raw y edge pulse
//   x_edge_g   x_edge gated by edge_en (combinational, to resolver)
//   y_edge_g   y_edge gated by edge_en (combinational, to resolver)
//   edge_en    high only during ARM
//   res_rst_b  resolver reset, active-low (low in IDLE and CLEAR)
//   res_sel    resolver to_sel_mux
//   sel_out    captured select (0 when no edge was seen)
//   no_edge    no gated edge seen during ARM
//   first_t    ARM cycle index of the first gated edge
//   sel_valid  result valid
//   sel_ready  downstream accept
//   win_cnt    count of handshaken windows (wraps)
//   busy       controller not idle
// -----------------------------------------------------------------------------
module comp_window_ctrl #(
  parameter int unsigned WIN_LEN = 16,
  parameter int unsigned CLR_CYC = 2,
  parameter int unsigned SEL_W   = 3,
  parameter int unsigned T_W     = $clog2(WIN_LEN)
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             en,
  input  logic             x_edge,
  input  logic             y_edge,
  output logic             x_edge_g,
  output logic             y_edge_g,
  output logic             edge_en,
  output logic             res_rst_b,
  input  logic [SEL_W-1:0] res_sel,
  output logic [SEL_W-1:0] sel_out,
  output logic             no_edge,
  output logic [T_W-1:0]   first_t,
  output logic             sel_valid,
  input  logic             sel_ready,
  output logic [15:0]      win_cnt,
  output logic             busy
);

  localparam int unsigned ARM_LEN  = WIN_LEN - CLR_CYC;
  localparam logic [T_W-1:0] CLR_LAST = T_W'(CLR_CYC - 1);
  localparam logic [T_W-1:0] ARM_LAST = T_W'(ARM_LEN - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CLEAR   = 3'd1;
  localparam logic [2:0] S_ARM     = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_HOLD    = 3'd4;

  logic [2:0]       state_q,     state_d;
  logic [T_W-1:0]   cnt_q,       cnt_d;
  logic             seen_q,      seen_d;
  logic             edge_en_q,   edge_en_d;
  logic             res_rst_b_q, res_rst_b_d;
  logic             sel_valid_q, sel_valid_d;
  logic [SEL_W-1:0] sel_out_q,   sel_out_d;
  logic             no_edge_q,   no_edge_d;
  logic [15:0]      win_cnt_q,   win_cnt_d;
  logic             busy_q,      busy_d;

  logic             any_edge;

  assign any_edge = x_edge | y_edge;

  // Next-state, phase counter, first-edge flag and result capture
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    seen_d    = seen_q;
    sel_out_d = sel_out_q;
    no_edge_d = no_edge_q;
    win_cnt_d = win_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (en) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
        end
      end

      S_CLEAR: begin
        seen_d = 1'b0;
        if (cnt_q == CLR_LAST) begin
          state_d = S_ARM;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + T_W'(1);
        end
      end

      S_ARM: begin
        // Simultaneous x/y edges collapse into one first edge
        if (!seen_q && any_edge) begin
          seen_d = 1'b1;
        end
        if (cnt_q == ARM_LAST) begin
          state_d = S_CAPTURE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + T_W'(1);
        end
      end

      S_CAPTURE: begin
        // Without an edge the resolver output is meaningless; report 0
        sel_out_d = seen_q ? res_sel : '0;
        no_edge_d = !seen_q;
        state_d   = S_HOLD;
      end

      S_HOLD: begin
        if (sel_ready) begin
          win_cnt_d = win_cnt_q + 16'd1;
          state_d   = en ? S_CLEAR : S_IDLE;
          cnt_d     = '0;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Phase outputs are decoded from the next state so they register in step
    edge_en_d   = (state_d == S_ARM);
    res_rst_b_d = !((state_d == S_IDLE) || (state_d == S_CLEAR));
    sel_valid_d = (state_d == S_HOLD);
    busy_d      = (state_d != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      seen_q      <= 1'b0;
      edge_en_q   <= 1'b0;
      res_rst_b_q <= 1'b0;
      sel_valid_q <= 1'b0;
      sel_out_q   <= '0;
      no_edge_q   <= 1'b0;
      win_cnt_q   <= 16'd0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      seen_q      <= seen_d;
      edge_en_q   <= edge_en_d;
      res_rst_b_q <= res_rst_b_d;
      sel_valid_q <= sel_valid_d;
      sel_out_q   <= sel_out_d;
      no_edge_q   <= no_edge_d;
      win_cnt_q   <= win_cnt_d;
      busy_q      <= busy_d;
    end
  end

`ifdef COMP_WIN_TIMESTAMP_EN
  logic [T_W-1:0] first_idx_q, first_idx_d;
  logic [T_W-1:0] first_t_q,   first_t_d;

  // Latch ARM index of the first edge; publish it at CAPTURE so it is
  // stable for the whole HOLD phase
  always_comb begin
    first_idx_d = first_idx_q;
    first_t_d   = first_t_q;
    case (state_q)
      S_CLEAR: begin
        first_idx_d = '0;
      end
      S_ARM: begin
        if (!seen_q && any_edge) begin
          first_idx_d = cnt_q;
        end
      end
      S_CAPTURE: begin
        first_t_d = seen_q ? first_idx_q : '0;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      first_idx_q <= '0;
      first_t_q   <= '0;
    end else begin
      first_idx_q <= first_idx_d;
      first_t_q   <= first_t_d;
    end
  end

  assign first_t = first_t_q;
`else
  assign first_t = '0;
`endif

  // Edge gates are combinational so the resolver sees edges in-cycle
  assign x_edge_g  = x_edge & edge_en_q;
  assign y_edge_g  = y_edge & edge_en_q;

  assign edge_en   = edge_en_q;
  assign res_rst_b = res_rst_b_q;
  assign sel_valid = sel_valid_q;
  assign sel_out   = sel_out_q;
  assign no_edge   = no_edge_q;
  assign win_cnt   = win_cnt_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_comp_window_ctrl.sv
// -----------------------------------------------------------------------------
// tb_comp_window_ctrl
//
// Scoreboarded bench for comp_window_ctrl. The stimulus process plans each
// window as a pair of per-ARM-cycle edge masks plus a resolver select; the
// expected result (first edge index, no_edge, forced select) is derived from
// those masks and pushed into a queue. A negedge monitor compares every
// valid cycle against the queue head and pops on handshake. The stimulus
// process also checks phase outputs against the window schedule: the window
// entered CLEAR at edge s, so after edge s+j the controller is in CLEAR for
// j < CLR_CYC, in ARM (index j-CLR_CYC) up to j = WIN_LEN-1, in CAPTURE at
// j = WIN_LEN and in HOLD from j = WIN_LEN+1.
// -----------------------------------------------------------------------------
module tb_comp_window_ctrl;

  localparam int WIN_LEN = 16;
  localparam int CLR_CYC = 2;
  localparam int ARM_LEN = WIN_LEN - CLR_CYC;
  localparam int SEL_W   = 3;
  localparam int T_W     = $clog2(WIN_LEN);

  typedef struct {
    logic [SEL_W-1:0] sel;
    logic             ne;
    logic [T_W-1:0]   ft;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_b = 1'b0;
  logic             en = 1'b0;
  logic             x_edge = 1'b0;
  logic             y_edge = 1'b0;
  logic             x_edge_g, y_edge_g, edge_en, res_rst_b;
  logic [SEL_W-1:0] res_sel = '0;
  logic [SEL_W-1:0] sel_out;
  logic             no_edge;
  logic [T_W-1:0]   first_t;
  logic             sel_valid;
  logic             sel_ready = 1'b0;
  logic [15:0]      win_cnt;
  logic             busy;

  comp_window_ctrl #(
    .WIN_LEN (WIN_LEN),
    .CLR_CYC (CLR_CYC),
    .SEL_W   (SEL_W),
    .T_W     (T_W)
  ) dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .en        (en),
    .x_edge    (x_edge),
    .y_edge    (y_edge),
    .x_edge_g  (x_edge_g),
    .y_edge_g  (y_edge_g),
    .edge_en   (edge_en),
    .res_rst_b (res_rst_b),
    .res_sel   (res_sel),
    .sel_out   (sel_out),
    .no_edge   (no_edge),
    .first_t   (first_t),
    .sel_valid (sel_valid),
    .sel_ready (sel_ready),
    .win_cnt   (win_cnt),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int          n_chk  = 0;
  int          n_pass = 0;
  exp_t        sb_q[$];
  logic [15:0] exp_wc = 16'd0;
  bit          chk_wc = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
  endtask

  // Reference: first ARM index with any edge, select forced to 0 if none
  function automatic exp_t model(input logic [SEL_W-1:0] rsel,
                                 input logic [ARM_LEN-1:0] xm,
                                 input logic [ARM_LEN-1:0] ym);
    exp_t e;
    int   first;
    first = -1;
    for (int i = ARM_LEN - 1; i >= 0; i--) begin
      if (xm[i] || ym[i]) first = i;
    end
    e.ne  = (first < 0);
    e.sel = e.ne ? '0 : rsel;
`ifdef COMP_WIN_TIMESTAMP_EN
    e.ft  = e.ne ? '0 : T_W'(first);
`else
    e.ft  = '0;
`endif
    return e;
  endfunction

  // Monitor: every valid cycle must match the queue head; pop on handshake
  always @(negedge clk) begin
    if (!rst_b) begin
      chk_wc = 1'b0;
    end else begin
      if (chk_wc) begin
        check("win_cnt_after_hs", 32'(win_cnt), 32'(exp_wc));
        check("valid_drop_after_hs", 32'(sel_valid), 32'd0);
        chk_wc = 1'b0;
      end
      if (sel_valid) begin
        if (sb_q.size() == 0) begin
          check("unexpected_valid", 32'(sel_valid), 32'd0);
        end else begin
          check("sel_out", 32'(sel_out), 32'(sb_q[0].sel));
          check("no_edge", 32'(no_edge), 32'(sb_q[0].ne));
          if (!sb_q[0].ne) check("first_t", 32'(first_t), 32'(sb_q[0].ft));
          check("win_cnt_hold", 32'(win_cnt), 32'(exp_wc));
          if (sel_ready) begin
            void'(sb_q.pop_front());
            exp_wc = exp_wc + 16'd1;
            chk_wc = 1'b1;
          end
        end
      end
    end
  end

  task automatic check_reset_vals();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_res_rst_b", 32'(res_rst_b), 32'd0);
    check("rst_edge_en", 32'(edge_en), 32'd0);
    check("rst_sel_valid", 32'(sel_valid), 32'd0);
    check("rst_sel_out", 32'(sel_out), 32'd0);
    check("rst_no_edge", 32'(no_edge), 32'd0);
    check("rst_first_t", 32'(first_t), 32'd0);
    check("rst_win_cnt", 32'(win_cnt), 32'd0);
  endtask

  task automatic check_idle();
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_res_rst_b", 32'(res_rst_b), 32'd0);
    check("idle_edge_en", 32'(edge_en), 32'd0);
    check("idle_sel_valid", 32'(sel_valid), 32'd0);
  endtask

  // Called at +1 after an edge with the controller idle; returns at +1
  // after the edge that moves it into CLEAR
  task automatic start_window();
    en = 1'b1;
    @(posedge clk); #1;
  endtask

  // Precondition: +1 after edge s (controller in CLEAR). Returns at +1
  // after the handshake edge.
  task automatic run_window(input logic [SEL_W-1:0] rsel,
                            input logic [ARM_LEN-1:0] xm,
                            input logic [ARM_LEN-1:0] ym,
                            input int hold_wait,
                            input bit keep_en);
    bit in_arm;
    sb_q.push_back(model(rsel, xm, ym));
    res_sel = rsel;
    for (int j = 0; j <= WIN_LEN; j++) begin
      in_arm = (j >= CLR_CYC) && (j < WIN_LEN);
      if (!keep_en && j == CLR_CYC + 5) en = 1'b0;
      if (in_arm) begin
        x_edge = xm[j - CLR_CYC];
        y_edge = ym[j - CLR_CYC];
      end else begin
        x_edge = 1'($urandom);
        y_edge = 1'($urandom);
      end
      #1;
      check("edge_en", 32'(edge_en), 32'(in_arm));
      check("res_rst_b", 32'(res_rst_b), 32'(j >= CLR_CYC));
      check("busy", 32'(busy), 32'd1);
      check("sel_valid_early", 32'(sel_valid), 32'd0);
      check("x_edge_g", 32'(x_edge_g), 32'(x_edge & in_arm));
      check("y_edge_g", 32'(y_edge_g), 32'(y_edge & in_arm));
      @(posedge clk); #1;
    end
    for (int h = 0; h <= hold_wait; h++) begin
      sel_ready = (h == hold_wait);
      x_edge = 1'($urandom);
      y_edge = 1'($urandom);
      #1;
      check("hold_valid", 32'(sel_valid), 32'd1);
      check("hold_edge_en", 32'(edge_en), 32'd0);
      check("hold_res_rst_b", 32'(res_rst_b), 32'd1);
      check("hold_x_edge_g", 32'(x_edge_g), 32'd0);
      check("hold_y_edge_g", 32'(y_edge_g), 32'd0);
      @(posedge clk); #1;
    end
    sel_ready = 1'b0;
    x_edge    = 1'b0;
    y_edge    = 1'b0;
    res_sel   = SEL_W'($urandom);
    if (keep_en) begin
      check("next_clear_busy", 32'(busy), 32'd1);
      check("next_clear_rst", 32'(res_rst_b), 32'd0);
    end else begin
      check_idle();
    end
  endtask

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [ARM_LEN-1:0] xm, ym;
    bit                 in_clear;
    bit                 keep;

    // Reset
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals();
    rst_b = 1'b1;
    @(posedge clk); #1;
    check_idle();

    // Abandon a window with reset during ARM cycle 7
    start_window();
    for (int j = 0; j < CLR_CYC + 7; j++) begin
      @(posedge clk); #1;
    end
    check("arm7_edge_en", 32'(edge_en), 32'd1);
    rst_b = 1'b0;
    en    = 1'b0;
    @(posedge clk); #1;
    check_reset_vals();
    rst_b  = 1'b1;
    exp_wc = 16'd0;
    repeat (WIN_LEN + 4) @(posedge clk);
    #1;
    check("post_abandon_valid", 32'(sel_valid), 32'd0);
    check("post_abandon_win_cnt", 32'(win_cnt), 32'd0);

    // x_edge high from ARM cycle 3, no y, select 001
    start_window();
    xm = '1;
    xm = xm << 3;
    run_window(3'b001, xm, '0, 0, 1'b1);

    // No edges with select 101: forced to 0, no_edge
    run_window(3'b101, '0, '0, 0, 1'b1);

    // Simultaneous x and y at ARM cycle 0
    run_window(3'b110, ARM_LEN'(1), ARM_LEN'(1), 0, 1'b1);

    // Ready held off for 5 HOLD cycles
    run_window(3'b011, ARM_LEN'(1) << 9, '0, 5, 1'b1);

    // Single edge in the last ARM cycle
    run_window(3'b111, '0, ARM_LEN'(1) << (ARM_LEN - 1), 1, 1'b0);
    in_clear = 1'b0;

    // Randomized windows
    for (int w = 0; w < 24; w++) begin
      keep = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 4) == 0) begin
        xm = '0;
        ym = '0;
      end else begin
        xm = ARM_LEN'($urandom & $urandom & $urandom);
        ym = ARM_LEN'($urandom & $urandom & $urandom);
      end
      if (!in_clear) begin
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
        check_idle();
        start_window();
      end
      run_window(SEL_W'($urandom), xm, ym, $urandom_range(0, 3), keep);
      in_clear = keep;
    end
    if (in_clear) begin
      run_window(3'b010, ARM_LEN'(1) << 4, '0, 0, 1'b0);
    end

    // Counter wrap, with en dropped mid-ARM
    @(posedge clk); #1;
    force dut.win_cnt_q = 16'hFFFF;
    @(posedge clk); #1;
    release dut.win_cnt_q;
    exp_wc = 16'hFFFF;
    start_window();
    run_window(3'b100, ARM_LEN'(1) << 2, ARM_LEN'(1) << 6, 2, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check_idle();
    check("wrap_win_cnt", 32'(win_cnt), 32'd0);
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
